// File: rtl/i2c_char_writer.sv
// i2c_char_writer: I2C master that writes one text cell (column, row, attribute bytes) to a display slave.
module i2c_char_writer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int CLK_DIV = 125,
  parameter int ATTR_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset_button,
  input  logic                    start,
  input  logic [7:0]              xtext,
  input  logic [7:0]              ytext,
  input  logic [8*ATTR_BYTES-1:0] charattr,
  output logic                    busy,
  output logic                    done,
  output logic                    nack,
  output logic                    scl_oe,
  output logic                    sda_oe,
  input  logic                    sda_in
);
  localparam int B = 3 + ATTR_BYTES;
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(B);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_BIT = 3'd2, S_ACK = 3'd3, S_STOP = 3'd4;
  logic [2:0] state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [CW-1:0] byte_q, byte_d;
  logic [8*B-1:0] shr_q, shr_d;
  logic abort_q, abort_d, done_q, done_d, nack_q, nack_d;
  logic scl_q, scl_d, sda_q, sda_d, sda_meta_q, sda_sync_q;
  logic tick, last, scl_want, sda_want;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign nack = nack_q;
  assign scl_oe = scl_q;
  assign sda_oe = sda_q;
  assign tick = div_q == DW'(CLK_DIV - 1);
  assign last = tick && qtr_q == 2'd3;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    byte_d = byte_q;
    shr_d = shr_q;
    abort_d = abort_q;
    done_d = 1'b0;
    nack_d = 1'b0;
    div_d = (!busy || tick) ? '0 : div_q + DW'(1);
    qtr_d = busy ? qtr_q + 2'(tick) : 2'd0;
    if (state_q == S_IDLE && start) begin
      state_d = S_START;
      shr_d = {SLAVE_ADDR, 1'b0, xtext, ytext, charattr};
      byte_d = '0;
      bit_d = 3'd7;
      abort_d = 1'b0;
    end
    if (state_q == S_ACK && tick && qtr_q == 2'd2) abort_d = sda_sync_q;
    if (last) begin
      case (state_q)
        S_START: state_d = S_BIT;
        S_BIT: begin
          shr_d = shr_q << 1;
          bit_d = bit_q == 3'd0 ? bit_q : bit_q - 3'd1;
          state_d = bit_q == 3'd0 ? S_ACK : S_BIT;
        end
        S_ACK: begin
          state_d = (abort_q || byte_q == CW'(B - 1)) ? S_STOP : S_BIT;
          byte_d = (abort_q || byte_q == CW'(B - 1)) ? byte_q : byte_q + CW'(1);
          bit_d = 3'd7;
        end
        S_STOP: begin
          state_d = S_IDLE;
          done_d = !abort_q;
          nack_d = abort_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
    scl_want = state_q == S_START ? qtr_q == 2'd3 :
               (state_q == S_BIT || state_q == S_ACK || state_q == S_STOP) ? qtr_q < 2'd2 : 1'b0;
    sda_want = state_q == S_START ? qtr_q >= 2'd2 :
               state_q == S_BIT   ? ~shr_q[8*B-1] :
               state_q == S_STOP  ? qtr_q != 2'd3 : 1'b0;
    // SCL moves first; SDA follows a cycle later so the two lines never toggle together
    scl_d = scl_want;
    sda_d = (scl_q != scl_want) ? sda_q : sda_want;
  end
  always_ff @(posedge clk) begin
    if (!reset_button) begin
      state_q <= S_IDLE;
      div_q <= '0;
      qtr_q <= 2'd0;
      bit_q <= 3'd0;
      byte_q <= '0;
      shr_q <= '0;
      abort_q <= 1'b0;
      done_q <= 1'b0;
      nack_q <= 1'b0;
      scl_q <= 1'b0;
      sda_q <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      shr_q <= shr_d;
      abort_q <= abort_d;
      done_q <= done_d;
      nack_q <= nack_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
    end
  end
endmodule

// File: tb/tb_i2c_char_writer.sv
// tb_i2c_char_writer: scoreboard bench with an I2C slave model that decodes bytes and answers ACK/NACK.
module tb_i2c_char_writer;
  logic clk = 1'b0, reset_button = 1'b0, start = 1'b0, sda_in;
  logic [7:0] xtext = 8'h00, ytext = 8'h00;
  logic [15:0] charattr = 16'h0000;
  logic busy, done, nack, scl_oe, sda_oe;
  i2c_char_writer #(.SLAVE_ADDR(7'h42), .CLK_DIV(4), .ATTR_BYTES(2)) dut (
    .clk(clk), .reset_button(reset_button), .start(start), .xtext(xtext), .ytext(ytext),
    .charattr(charattr), .busy(busy), .done(done), .nack(nack), .scl_oe(scl_oe),
    .sda_oe(sda_oe), .sda_in(sda_in)
  );
  always #5 clk = ~clk;
  typedef struct {logic is_nack; int t0; int lat;} evt_t;
  logic [7:0] exp_b[$];
  evt_t exp_e[$];
  evt_t e;
  int cyc = 0, checks = 0, errors = 0, nack_at = -1, rst_req = 0, rst_ack = 0, tmo = 0;
  int bcnt = 0, nbyte = 0, starts = 0, stops = 0, simul = 0;
  logic mon_en = 1'b0, slave_clr = 1'b1, end_req = 1'b0, end_ack = 1'b0;
  logic pull = 1'b0, scl_p = 1'b1, sda_p = 1'b1, acking = 1'b0, scl_oe_p = 1'b0, sda_oe_p = 1'b0;
  logic [7:0] sh = 8'h00;
  logic scl_bus, sda_bus;
  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | pull);
  assign sda_in = sda_bus;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Slave model plus scoreboard monitor; the only process that compares or counts
  always @(negedge clk) begin
    if (slave_clr) begin
      pull <= 1'b0; acking <= 1'b0; bcnt <= 0; nbyte <= 0; starts <= 0; stops <= 0;
    end else if (scl_bus && scl_p && sda_p && !sda_bus) begin
      starts <= starts + 1; bcnt <= 0; acking <= 1'b0; nbyte <= 0;
    end else if (scl_bus && scl_p && !sda_p && sda_bus) begin
      stops <= stops + 1;
    end else if (scl_bus && !scl_p && bcnt < 8) begin
      sh <= {sh[6:0], sda_bus};
      bcnt <= bcnt + 1;
      if (bcnt == 7 && mon_en) begin
        if (exp_b.size() == 0) chk("extra_byte", int'({sh[6:0], sda_bus}), -1);
        else chk("byte", int'({sh[6:0], sda_bus}), int'(exp_b.pop_front()));
      end
    end else if (!scl_bus && scl_p) begin
      if (acking) begin
        pull <= 1'b0; acking <= 1'b0; bcnt <= 0;
      end else if (bcnt == 8) begin
        pull <= (nbyte != nack_at); acking <= 1'b1; nbyte <= nbyte + 1;
      end
    end
    scl_p <= scl_bus;
    sda_p <= sda_bus;
    if (scl_oe != scl_oe_p && sda_oe != sda_oe_p && (scl_oe || sda_oe)) simul <= simul + 1;
    scl_oe_p <= scl_oe;
    sda_oe_p <= sda_oe;
    if (done || nack) begin
      if (exp_e.size() == 0) chk("unexpected_evt", {30'd0, nack, done}, 0);
      else begin
        e = exp_e.pop_front();
        chk("evt_nack", int'(nack), int'(e.is_nack));
        chk("evt_done", int'(done), int'(!e.is_nack));
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_end", int'(busy), 0);
        chk("starts", starts, 1);
        chk("stops", stops, 1);
        starts <= 0;
        stops <= 0;
      end
    end
    if (rst_req != rst_ack) begin
      chk("rst_scl_oe", int'(scl_oe), 0);
      chk("rst_sda_oe", int'(sda_oe), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_nack", int'(nack), 0);
      rst_ack <= rst_req;
    end
    if (end_req && !end_ack) begin
      chk("bytes_left", exp_b.size(), 0);
      chk("evts_left", exp_e.size(), 0);
      chk("timeouts", tmo, 0);
      chk("simul_edges", simul, 0);
      end_ack <= 1'b1;
    end
  end
  task automatic go(input logic [7:0] x, input logic [7:0] y, input logic [15:0] a,
                    input logic nk, input int lat, input int nak_idx);
    @(negedge clk);
    nack_at = nak_idx;
    xtext = x; ytext = y; charattr = a; start = 1'b1;
    exp_e.push_back('{nk, cyc, lat});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_e.size() == 0) return;
    end
    tmo++;
    $display("FAIL wait_idle: still busy=%0b with %0d events pending", busy, exp_e.size());
  endtask
  task automatic rst_check();
    @(posedge clk);
    #1 rst_req++;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_check();
    reset_button = 1'b1;
    slave_clr = 1'b0;
    // T1: reset in the middle of the address byte
    @(negedge clk);
    xtext = 8'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    reset_button = 1'b0;
    rst_check();
    reset_button = 1'b1;
    slave_clr = 1'b1;
    repeat (3) @(negedge clk);
    slave_clr = 1'b0;
    mon_en = 1'b1;
    // T2: full write, all ACKed
    exp_b.push_back(8'h84); exp_b.push_back(8'h12); exp_b.push_back(8'h05);
    exp_b.push_back(8'hA5); exp_b.push_back(8'h5A);
    go(8'h12, 8'h05, 16'hA55A, 1'b0, 753, -1);
    wait_idle();
    // T3: address NACK
    exp_b.push_back(8'h84);
    go(8'h12, 8'h05, 16'hA55A, 1'b1, 177, 0);
    wait_idle();
    // T4: NACK on ytext
    exp_b.push_back(8'h84); exp_b.push_back(8'h12); exp_b.push_back(8'h05);
    go(8'h12, 8'h05, 16'hA55A, 1'b1, 465, 2);
    wait_idle();
    // T5: start while busy must be ignored
    exp_b.push_back(8'h84); exp_b.push_back(8'h12); exp_b.push_back(8'h05);
    exp_b.push_back(8'hA5); exp_b.push_back(8'h5A);
    go(8'h12, 8'h05, 16'hA55A, 1'b0, 753, -1);
    repeat (250) @(negedge clk);
    xtext = 8'hFF; ytext = 8'hFF; charattr = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    // T6: back-to-back, second start in the done cycle
    exp_b.push_back(8'h84); exp_b.push_back(8'h01); exp_b.push_back(8'h02);
    exp_b.push_back(8'hBE); exp_b.push_back(8'hEF);
    go(8'h01, 8'h02, 16'hBEEF, 1'b0, 753, -1);
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    if (!done) begin
      tmo++;
      $display("FAIL wait_done: done never pulsed");
    end
    exp_b.push_back(8'h84); exp_b.push_back(8'h3C); exp_b.push_back(8'h7E);
    exp_b.push_back(8'h0F); exp_b.push_back(8'h0F);
    xtext = 8'h3C; ytext = 8'h7E; charattr = 16'h0F0F; start = 1'b1;
    exp_e.push_back('{1'b0, cyc, 753});
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
